rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback requesters:
//  the in-order pipeline WB stage (P) and the multi-cycle unit (M, divider/long-latency load).
//  P has fixed priority; a starvation counter forces a grant to M after MAX_WAIT lost cycles.
//  Winner is registered into rf_wen/rf_rd/rf_rd_v, which drive the register file write port.
// PARAMETERS
//  XLEN      32  data width of writeback values
//  MAX_WAIT  4   consecutive cycles M may lose before it is forced (range 1..15)
// PORTS
//  clk       in   1     system clock; all state updates on posedge
//  rst       in   1     synchronous, active-low reset
//  p_valid   in   1     pipeline WB write request
//  p_ready   out  1     P accepted this cycle (comb.)
//  p_rd      in   5     P destination register
//  p_data    in   XLEN  P writeback value
//  m_valid   in   1     multi-cycle unit write request
//  m_ready   out  1     M accepted this cycle (comb.)
//  m_rd      in   5     M destination register
//  m_data    in   XLEN  M writeback value
//  rf_wen    out  1     register file write enable (registered)
//  rf_rd     out  5     register file write address (registered)
//  rf_rd_v   out  XLEN  register file write data (registered)
//  p_stall   out  1     high when P has valid but is refused; upstream freezes pipeline
// BEHAVIOUR
//  - Reset (rst==0 at posedge): rf_wen=0, rf_rd=0, rf_rd_v=0, wait_cnt=0, state=PRI_P.
//    Reset mid-transfer drops any in-flight grant; requesters re-present after reset.
//  - Handshake: transfer when valid&&ready. Requester holds valid/rd/data stable until accepted.
//    ready is combinational from valid inputs and state; never depends on own ready.
//  - States: PRI_P (default), FORCE_M.
//    PRI_P: p_valid -> grant P; else m_valid -> grant M. Both valid -> P wins, wait_cnt++.
//      If the increment makes wait_cnt==MAX_WAIT -> next state FORCE_M.
//    FORCE_M: grant M unconditionally (p_ready=0, p_stall=p_valid); on M transfer -> PRI_P.
//      If m_valid drops in FORCE_M (protocol violation), return to PRI_P, no grant.
//  - wait_cnt clears on every M transfer; holds when M not valid; 4-bit, never wraps.
//  - At most one grant per cycle; exactly one of p_ready/m_ready high when any valid.
//  - Latency: accepted request appears on rf_* the next cycle (1 cycle); rf_wen=0 when no grant.
//  - rd==0: request is accepted (ready=1) but rf_wen stays 0 next cycle (x0 hard-wired).
//  - Same-rd ordering between P and M is the issue scoreboard's responsibility; arbiter does
//    not reorder beyond the rules above.
//  - p_stall = p_valid && !p_ready.
// CONFIGURATION
//  RF_WB_ARB_STATS_EN defined: adds outputs conflict_cnt[15:0] (cycles with p_valid&&m_valid)
//    and force_cnt[15:0] (FORCE_M grants); both reset to 0, saturate at 16'hFFFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 P only: p_valid=1,p_rd=5,p_data=32'h1234 -> p_ready=1; next cycle rf_wen=1,rf_rd=5,rf_rd_v=32'h1234.
//  2 Both valid, MAX_WAIT=4, P rd=1..4, M rd=7 data=32'hDEAD held -> P wins 4 cycles, M granted
//    5th cycle with p_stall=1; rf_rd=7,rf_rd_v=32'hDEAD one cycle later; state back to PRI_P.
//  3 M only, m_rd=0, m_data=32'hFFFF -> m_ready=1; next cycle rf_wen=0.
//  4 Idle cycles (no valids) -> rf_wen=0 each cycle; wait_cnt unchanged.
//  5 rst=0 asserted during FORCE_M with both valid -> next cycle rf_wen=0, state PRI_P, wait_cnt=0;
//    first post-reset cycle grants P.
//  6 STATS_EN: 6 conflict cycles at MAX_WAIT=4 -> conflict_cnt=6, force_cnt=1.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundle for the register-file writeback arbiter: two requester handshakes
// (P = in-order pipeline WB stage, M = multi-cycle unit) and the registered
// register-file write port.
//   slave  modport : arbiter side (takes requests, drives ready/stall/rf_*)
//   master modport : requester / environment side
// Signals:
//   p_valid/p_ready/p_rd/p_data  pipeline writeback request
//   m_valid/m_ready/m_rd/m_data  multi-cycle unit writeback request
//   rf_wen/rf_rd/rf_rd_v         register file write port (registered)
//   p_stall                      P holds a request that is being refused
// -----------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            p_valid;
  logic            p_ready;
  logic [4:0]      p_rd;
  logic [XLEN-1:0] p_data;
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_rd_v;
  logic            p_stall;

  modport slave (
    input  p_valid, p_rd, p_data, m_valid, m_rd, m_data,
    output p_ready, m_ready, rf_wen, rf_rd, rf_rd_v, p_stall
  );

  modport master (
    output p_valid, p_rd, p_data, m_valid, m_rd, m_data,
    input  p_ready, m_ready, rf_wen, rf_rd, rf_rd_v, p_stall
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between the pipeline WB stage (P)
// and the multi-cycle unit (M). P has fixed priority; after M has lost
// MAX_WAIT consecutive conflicts the arbiter enters FORCE_M and grants M once.
// The winner is registered onto rf_wen/rf_rd/rf_rd_v (1-cycle latency).
// Writes to x0 are accepted but never raise rf_wen.
// Ports:
//   clk   system clock, all state on posedge
//   rst   synchronous, active-low reset
//   bus   rf_wb_arbiter_if.slave (requests, readies, p_stall, rf_* write port)
//   conflict_cnt[15:0], force_cnt[15:0]  only when RF_WB_ARB_STATS_EN is
//         defined: saturating counts of p_valid&&m_valid cycles and of
//         forced M grants.
// Optional feature macro: RF_WB_ARB_STATS_EN
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  rf_wb_arbiter_if.slave      bus
`ifdef RF_WB_ARB_STATS_EN
  ,
  output logic [15:0]         conflict_cnt,
  output logic [15:0]         force_cnt
`endif
);

  typedef enum logic {PRI_P = 1'b0, FORCE_M = 1'b1} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Counter never wraps: a 15 stays 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [3:0]      wait_inc;
  logic            in_pri;
  logic            p_fire;
  logic            m_fire;
  logic            rf_wen_q;
  logic [4:0]      rf_rd_q;
  logic [XLEN-1:0] rf_data_q;

  // Request/grant stage (combinational handshake)
  assign in_pri      = (state == PRI_P);
  assign bus.p_ready = in_pri && bus.p_valid;
  assign bus.m_ready = bus.m_valid && (!in_pri || !bus.p_valid);
  assign bus.p_stall = bus.p_valid && !bus.p_ready;
  assign p_fire      = bus.p_valid && bus.p_ready;
  assign m_fire      = bus.m_valid && bus.m_ready;
  assign wait_inc    = sat_inc4(wait_cnt);

  // Write-port register stage and arbitration state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= PRI_P;
      wait_cnt  <= 4'd0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= '0;
    end else begin
      rf_wen_q <= 1'b0;
      if (p_fire) begin
        rf_wen_q  <= (bus.p_rd != 5'd0);
        rf_rd_q   <= bus.p_rd;
        rf_data_q <= bus.p_data;
      end else if (m_fire) begin
        rf_wen_q  <= (bus.m_rd != 5'd0);
        rf_rd_q   <= bus.m_rd;
        rf_data_q <= bus.m_data;
      end

      if (state == PRI_P) begin
        if (p_fire && bus.m_valid) begin
          wait_cnt <= wait_inc;
          // >= also covers a count left at MAX_WAIT by an M drop in FORCE_M.
          if (wait_inc >= MAX_WAIT_C) state <= FORCE_M;
        end else if (m_fire) begin
          wait_cnt <= 4'd0;
        end
      end else begin
        // Leave FORCE_M whether M transferred or (illegally) withdrew.
        state <= PRI_P;
        if (m_fire) wait_cnt <= 4'd0;
      end
    end
  end

  assign bus.rf_wen  = rf_wen_q;
  assign bus.rf_rd   = rf_rd_q;
  assign bus.rf_rd_v = rf_data_q;

`ifdef RF_WB_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= 16'd0;
      force_cnt    <= 16'd0;
    end else begin
      if (bus.p_valid && bus.m_valid) conflict_cnt <= sat_inc16(conflict_cnt);
      if (m_fire && !in_pri)          force_cnt    <= sat_inc16(force_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed, table-driven bench for rf_wb_arbiter (XLEN=32, MAX_WAIT=4).
// Each table row is applied for one cycle; readies/stall are checked before
// the clock edge, the rf_* write port just after it.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.XLEN(32)) bus ();

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] force_cnt;
`endif

  rf_wb_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RF_WB_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .force_cnt    (force_cnt)
`endif
  );

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_pr;
    logic        e_mr;
    logic        e_st;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic e_pr, input logic e_mr, input logic e_st,
                              input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_d);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_pr = e_pr; v.e_mr = e_mr; v.e_st = e_st;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.p_valid = pv; bus.p_rd = prd; bus.p_data = pd;
    bus.m_valid = mv; bus.m_rd = mrd; bus.m_data = md;
  endtask

  // Called at posedge+1: apply, check handshake, clock, check write port.
  task automatic run_vec(input string tag, input vec_t v);
    drive(v.pv, v.prd, v.pd, v.mv, v.mrd, v.md);
    #1;
    chk({tag, " p_ready"}, 64'(bus.p_ready), 64'(v.e_pr));
    chk({tag, " m_ready"}, 64'(bus.m_ready), 64'(v.e_mr));
    chk({tag, " p_stall"}, 64'(bus.p_stall), 64'(v.e_st));
    @(posedge clk);
    #1;
    chk({tag, " rf_wen"}, 64'(bus.rf_wen), 64'(v.e_wen));
    if (v.e_wen) begin
      chk({tag, " rf_rd"},   64'(bus.rf_rd),   64'(v.e_rd));
      chk({tag, " rf_rd_v"}, 64'(bus.rf_rd_v), 64'(v.e_d));
    end
  endtask

  // Both requesters valid for one cycle; expectation given by caller.
  task automatic conflict(input string tag, input logic [4:0] prd, input logic e_mgrant);
    vec_t v;
    if (e_mgrant)
      v = mk(1, prd, {27'd0, prd}, 1, 5'd7, 32'hDEAD, 0, 1, 1, 1, 5'd7, 32'hDEAD);
    else
      v = mk(1, prd, {27'd0, prd}, 1, 5'd7, 32'hDEAD, 1, 0, 0, (prd != 0), prd, {27'd0, prd});
    run_vec(tag, v);
  endtask

  initial begin
    // Sequence: P only, M to x0, idle, conflict run to FORCE_M, return to
    // PRI_P, then a conflict run interrupted by idle cycles (count holds).
    vt[0]  = mk(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,     1, 0, 0, 1, 5'd5, 32'h1234);
    vt[1]  = mk(0, 5'd0, 32'h0,    1, 5'd0, 32'hFFFF,  0, 1, 0, 0, 5'd0, 32'h0);
    vt[2]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 0, 5'd0, 32'h0);
    vt[3]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 0, 5'd0, 32'h0);
    vt[4]  = mk(1, 5'd1, 32'h11,   1, 5'd7, 32'hDEAD,  1, 0, 0, 1, 5'd1, 32'h11);
    vt[5]  = mk(1, 5'd2, 32'h22,   1, 5'd7, 32'hDEAD,  1, 0, 0, 1, 5'd2, 32'h22);
    vt[6]  = mk(1, 5'd3, 32'h33,   1, 5'd7, 32'hDEAD,  1, 0, 0, 1, 5'd3, 32'h33);
    vt[7]  = mk(1, 5'd4, 32'h44,   1, 5'd7, 32'hDEAD,  1, 0, 0, 1, 5'd4, 32'h44);
    vt[8]  = mk(1, 5'd5, 32'h55,   1, 5'd7, 32'hDEAD,  0, 1, 1, 1, 5'd7, 32'hDEAD);
    vt[9]  = mk(1, 5'd5, 32'h55,   0, 5'd0, 32'h0,     1, 0, 0, 1, 5'd5, 32'h55);
    vt[10] = mk(1, 5'd1, 32'hA1,   1, 5'd9, 32'h99,    1, 0, 0, 1, 5'd1, 32'hA1);
    vt[11] = mk(1, 5'd2, 32'hA2,   1, 5'd9, 32'h99,    1, 0, 0, 1, 5'd2, 32'hA2);
    vt[12] = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 0, 5'd0, 32'h0);
    vt[13] = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 0, 5'd0, 32'h0);
    vt[14] = mk(1, 5'd3, 32'hA3,   1, 5'd9, 32'h99,    1, 0, 0, 1, 5'd3, 32'hA3);
    vt[15] = mk(1, 5'd4, 32'hA4,   1, 5'd9, 32'h99,    1, 0, 0, 1, 5'd4, 32'hA4);
    vt[16] = mk(1, 5'd6, 32'hA6,   1, 5'd9, 32'h99,    0, 1, 1, 1, 5'd9, 32'h99);
    vt[17] = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 0, 5'd0, 32'h0);

    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_wen",  64'(bus.rf_wen),  64'd0);
    chk("reset rf_rd",   64'(bus.rf_rd),   64'd0);
    chk("reset rf_rd_v", 64'(bus.rf_rd_v), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Reset while in FORCE_M: grant is dropped, state and count restart.
    for (int i = 1; i <= 4; i++) conflict($sformatf("pre_rst%0d", i), 5'(i), 1'b0);
    drive(1, 5'd3, 32'h3, 1, 5'd7, 32'hDEAD);
    rst = 1'b0;
    #1;
    chk("force_m before reset m_ready", 64'(bus.m_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("reset in force_m rf_wen", 64'(bus.rf_wen), 64'd0);
    rst = 1'b1;
    // Cleared count: four P wins again before M is forced on the fifth.
    for (int i = 1; i <= 4; i++) conflict($sformatf("post_rst%0d", i), 5'(i + 10), 1'b0);
    conflict("post_rst5", 5'd15, 1'b1);

    // M withdraws while forced: no grant, P refused, then PRI_P again.
    for (int i = 1; i <= 4; i++) conflict($sformatf("pre_drop%0d", i), 5'(i), 1'b0);
    run_vec("m_drop", mk(1, 5'd8, 32'h88, 0, 5'd0, 32'h0, 0, 0, 1, 0, 5'd0, 32'h0));
    run_vec("after_drop", mk(1, 5'd8, 32'h88, 0, 5'd0, 32'h0, 1, 0, 0, 1, 5'd8, 32'h88));

`ifdef RF_WB_ARB_STATS_EN
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("stats reset conflict_cnt", 64'(conflict_cnt), 64'd0);
    for (int i = 1; i <= 4; i++) conflict($sformatf("stats%0d", i), 5'(i), 1'b0);
    conflict("stats5", 5'd5, 1'b1);
    conflict("stats6", 5'd6, 1'b0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("conflict_cnt", 64'(conflict_cnt), 64'd6);
    chk("force_cnt",    64'(force_cnt),    64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
